// File: rtl/router_in_rx.sv
// router_in_rx: serial router input-port receiver, deserialises frames into a show-ahead byte FIFO
// Ports:
//   clk, reset                  clock (rising edge) and asynchronous active-high reset
//   frame_n, valid_n, data      serial frame from the input agent (active-low frame/qualifier)
//   busy_n                      active-low backpressure to the sender
//   out_valid, out_ready        FIFO head handshake to the switch core
//   out_addr, out_data, out_last head byte: destination, payload, last-of-frame flag
//   err, err_code               one-cycle error pulse and its cause
module router_in_rx #(
    parameter int ADDR_W     = 4,
    parameter int PAD_CYCLES = 5,
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              frame_n,
    input  logic              valid_n,
    input  logic              data,
    output logic              busy_n,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              err,
    output logic [1:0]        err_code
);
    localparam int AC_W  = $clog2(ADDR_W + 1);
    localparam int PC_W  = $clog2(PAD_CYCLES + 1);
    localparam int BC_W  = $clog2(DATA_W + 1);
    localparam int PW    = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int EW    = ADDR_W + DATA_W + 1;
    localparam logic [AC_W-1:0] A_LAST = AC_W'(ADDR_W - 1);
    localparam logic [PC_W-1:0] P_LAST = PC_W'(PAD_CYCLES - 1);
    localparam logic [BC_W-1:0] B_LAST = BC_W'(DATA_W - 1);

    typedef enum logic [2:0] {IDLE, ADDR, PAD, DATA, DROP} state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_addr;
    logic [AC_W-1:0]    r_acnt;
    logic [PC_W-1:0]    r_pcnt;
    logic [DATA_W-1:0]  r_shift;
    logic [BC_W-1:0]    r_bcnt;
    logic [EW-1:0]      r_mem [DEPTH];
    logic [PW-1:0]      r_wp;
    logic [PW-1:0]      r_rp;
    logic [CNT_W-1:0]   r_count;
    logic               r_busy_n;
    logic               r_err;
    logic [1:0]         r_code;

    state_t             w_next;
    logic               w_err;
    logic [1:0]         w_code;
    logic               w_done;
    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic [DATA_W-1:0]  w_bit;
    logic [CNT_W-1:0]   w_count_next;

    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        w_code = 2'd0;
        w_done = 1'b0;
        w_bit  = r_shift | (DATA_W'(data) << r_bcnt);
        w_pop  = out_valid & out_ready;
        w_full = r_count == CNT_W'(DEPTH);
        case (r_state)
            IDLE: w_next = frame_n ? IDLE : (ADDR_W == 1 ? PAD : ADDR);
            ADDR, PAD: begin
                // abort outranks protocol when both strike together
                if (frame_n) begin
                    w_err  = 1'b1;
                    w_code = 2'd1;
                    w_next = IDLE;
                end else if (!valid_n) begin
                    w_err  = 1'b1;
                    w_next = DROP;
                end else if (r_state == ADDR)
                    w_next = r_acnt == A_LAST ? PAD : ADDR;
                else
                    w_next = r_pcnt == P_LAST ? DATA : PAD;
            end
            DATA: begin
                if (valid_n) begin
                    if (frame_n) begin
                        w_err  = 1'b1;
                        w_code = 2'd1;
                        w_next = IDLE;
                    end
                end else if (r_bcnt == B_LAST) begin
                    w_done = 1'b1;
                    // a same-edge pop frees the slot, so full alone is not overflow
                    if (w_full && !w_pop) begin
                        w_err  = 1'b1;
                        w_code = 2'd3;
                        w_next = frame_n ? IDLE : DROP;
                    end else if (frame_n)
                        w_next = IDLE;
                end else if (frame_n) begin
                    w_err  = 1'b1;
                    w_code = 2'd2;
                    w_next = IDLE;
                end
            end
            DROP: w_next = frame_n ? IDLE : DROP;
            default: w_next = IDLE;
        endcase
        w_push       = w_done & (!w_full | w_pop);
        w_count_next = r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_addr   <= '0;
            r_acnt   <= AC_W'(1);
            r_pcnt   <= '0;
            r_shift  <= '0;
            r_bcnt   <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_count  <= '0;
            r_busy_n <= 1'b1;
            r_err    <= 1'b0;
            r_code   <= 2'd0;
        end else begin
            r_state  <= w_next;
            r_addr   <= r_state == IDLE ? ADDR_W'(data) :
                        r_state == ADDR ? r_addr | (ADDR_W'(data) << r_acnt) : r_addr;
            r_acnt   <= r_state == ADDR ? r_acnt + AC_W'(1) : AC_W'(1);
            r_pcnt   <= r_state == PAD ? r_pcnt + PC_W'(1) : '0;
            r_shift  <= (r_state != DATA || w_done) ? '0 : (!valid_n ? w_bit : r_shift);
            r_bcnt   <= (r_state != DATA || w_done) ? '0 : (!valid_n ? r_bcnt + BC_W'(1) : r_bcnt);
            r_wp     <= r_wp + PW'(w_push);
            r_rp     <= r_rp + PW'(w_pop);
            r_count  <= w_count_next;
            r_busy_n <= w_count_next < CNT_W'(DEPTH - 1);
            r_err    <= w_err;
            r_code   <= w_code;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wp] <= {r_addr, w_bit, frame_n};
    end

    assign out_valid = r_count != '0;
    // head gated so stale storage never shows after reset or drain
    assign {out_addr, out_data, out_last} = out_valid ? r_mem[r_rp] : '0;
    assign busy_n    = r_busy_n;
    assign err       = r_err;
    assign err_code  = r_code;
endmodule

// File: tb/tb_router_in_rx.sv
// tb_router_in_rx: directed scoreboard bench for router_in_rx
module tb_router_in_rx;
    logic       clk = 1'b0;
    logic       reset;
    logic       frame_n;
    logic       valid_n;
    logic       data;
    logic       busy_n;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_addr;
    logic [7:0] out_data;
    logic       out_last;
    logic       err;
    logic [1:0] err_code;

    int checks = 0;
    int errors = 0;
    logic [12:0] exp_q [$];
    logic [1:0]  err_q [$];

    router_in_rx dut (
        .clk(clk), .reset(reset), .frame_n(frame_n), .valid_n(valid_n), .data(data),
        .busy_n(busy_n), .out_valid(out_valid), .out_ready(out_ready),
        .out_addr(out_addr), .out_data(out_data), .out_last(out_last),
        .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] expv);
        checks++;
        assert (got === expv) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // drive one bit-time at the negedge, score the head if it pops on the coming edge,
    // then score any err pulse produced by that edge
    task automatic cyc(input logic f, input logic v, input logic d);
        frame_n = f;
        valid_n = v;
        data    = d;
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL extra_byte: got %h expected no byte", {out_addr, out_data, out_last});
            end else
                chk("byte", {out_addr, out_data, out_last}, exp_q.pop_front());
        end
        @(posedge clk);
        @(negedge clk);
        if (err === 1'b1) begin
            if (err_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL extra_err: got code %0d expected no err", err_code);
            end else
                chk("err_code", err_code, err_q.pop_front());
        end
    endtask

    task automatic send_hdr(input logic [3:0] a);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, a[i]);
        repeat (5) cyc(1'b0, 1'b1, 1'b0);
    endtask

    task automatic send_byte(input logic [3:0] a, input logic [7:0] b, input logic last,
                             input int stall, input logic expect_out);
        if (expect_out) exp_q.push_back({a, b, last});
        for (int i = 0; i < 8; i++) begin
            cyc(last && i == 7, 1'b0, b[i]);
            if (i == stall) cyc(1'b0, 1'b1, 1'b0);
        end
    endtask

    initial begin
        reset = 1'b1; frame_n = 1'b1; valid_n = 1'b1; data = 1'b0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy_n", busy_n, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_addr", out_addr, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_err", err, 0);
        chk("rst_err_code", err_code, 0);
        reset = 1'b0;
        cyc(1'b1, 1'b1, 1'b0);

        // clean frame with latency checks
        out_ready = 1'b1;
        send_hdr(4'hA);
        send_byte(4'hA, 8'h3C, 1'b0, -1, 1'b1);
        chk("lat0_valid", out_valid, 1);
        send_byte(4'hA, 8'hA5, 1'b1, -1, 1'b1);
        chk("lat1_valid", out_valid, 1);
        chk("lat1_last", out_last, 1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("clean_drained", out_valid, 0);
        chk("clean_q", exp_q.size(), 0);

        // same frame with a stall after bit 3 of each byte
        send_hdr(4'hA);
        send_byte(4'hA, 8'h3C, 1'b0, 3, 1'b1);
        chk("stall_lat0", out_valid, 1);
        send_byte(4'hA, 8'hA5, 1'b1, 3, 1'b1);
        chk("stall_lat1", out_valid, 1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("stall_q", exp_q.size(), 0);

        // backpressure and overflow
        out_ready = 1'b0;
        send_hdr(4'h5);
        send_byte(4'h5, 8'h11, 1'b0, -1, 1'b1);
        send_byte(4'h5, 8'h22, 1'b0, -1, 1'b1);
        chk("busy_after2", busy_n, 1);
        send_byte(4'h5, 8'h33, 1'b0, -1, 1'b1);
        chk("busy_after3", busy_n, 0);
        send_byte(4'h5, 8'h44, 1'b0, -1, 1'b1);
        err_q.push_back(2'd3);
        send_byte(4'h5, 8'h55, 1'b1, -1, 1'b0);
        chk("ovf_err_q", err_q.size(), 0);
        chk("ovf_valid", out_valid, 1);
        chk("ovf_busy", busy_n, 0);
        out_ready = 1'b1;
        repeat (4) cyc(1'b1, 1'b1, 1'b0);
        chk("ovf_drained", out_valid, 0);
        chk("ovf_busy_free", busy_n, 1);
        chk("ovf_q", exp_q.size(), 0);

        // misaligned end on payload bit 12, then a clean frame
        send_hdr(4'h3);
        send_byte(4'h3, 8'h5A, 1'b0, -1, 1'b1);
        err_q.push_back(2'd2);
        for (int i = 0; i < 4; i++) cyc(i == 3, 1'b0, i[0]);
        chk("mis_err_q", err_q.size(), 0);
        send_hdr(4'h6);
        send_byte(4'h6, 8'hC3, 1'b1, -1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("mis_q", exp_q.size(), 0);

        // valid_n low in the 3rd pad cycle
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, i == 0 || i == 3);
        repeat (2) cyc(1'b0, 1'b1, 1'b0);
        err_q.push_back(2'd0);
        cyc(1'b0, 1'b0, 1'b1);
        chk("proto_err_q", err_q.size(), 0);
        for (int i = 0; i < 20; i++) cyc(1'b0, 1'b0, i[0]);
        cyc(1'b1, 1'b1, 1'b0);
        chk("drop_no_out", out_valid, 0);

        // abort in ADDR, then a frame on the very next cycle
        cyc(1'b0, 1'b1, 1'b1);
        cyc(1'b0, 1'b1, 1'b0);
        err_q.push_back(2'd1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("abort_err_q", err_q.size(), 0);
        send_hdr(4'h2);
        send_byte(4'h2, 8'h81, 1'b1, -1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("abort_q", exp_q.size(), 0);

        // asynchronous reset mid-DATA with two bytes buffered
        out_ready = 1'b0;
        send_hdr(4'h7);
        send_byte(4'h7, 8'h12, 1'b0, -1, 1'b1);
        send_byte(4'h7, 8'h34, 1'b0, -1, 1'b1);
        repeat (3) cyc(1'b0, 1'b0, 1'b1);
        chk("pre_rst_valid", out_valid, 1);
        #2 reset = 1'b1;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_addr", out_addr, 0);
        chk("arst_data", out_data, 0);
        chk("arst_last", out_last, 0);
        chk("arst_busy", busy_n, 1);
        chk("arst_err", err, 0);
        exp_q.delete();
        cyc(1'b1, 1'b1, 1'b0);
        reset = 1'b0;
        out_ready = 1'b1;
        cyc(1'b1, 1'b1, 1'b0);
        chk("post_rst_empty", out_valid, 0);
        send_hdr(4'h1);
        send_byte(4'h1, 8'hF0, 1'b1, -1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        chk("post_rst_q", exp_q.size(), 0);
        chk("final_err_q", err_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/router_in_rx.md
Name: router_in_rx

Overview:
- DUT-side receiver for the router serial input-port protocol. Samples `frame_n`, `valid_n` and `data` driven by the input agent. Drives `busy_n` back to the agent for flow control.
- Deserialises each frame into a destination address plus payload bytes. Hands the bytes to the switch core through a small FIFO with a valid/ready handshake.
- One instance per router input port.

Parameters:
- ADDR_W, 4, destination address bits, sent LSB first.
- PAD_CYCLES, 5, mandatory pad cycles between address and payload.
- DATA_W, 8, payload word width, sent LSB first.
- DEPTH, 4, output FIFO entries (power of 2, >= 2).

Ports:
- clk  input  1  port clock; all sampling on rising edge.
- reset  input  1  asynchronous, active-high reset.
- frame_n  input  1  active-low frame; low for whole frame, high on final payload bit.
- valid_n  input  1  active-low payload-bit qualifier.
- data  input  1  serial address/payload bit.
- busy_n  output  1  active-low backpressure to the sender.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts head when out_valid & out_ready.
- out_addr  output  ADDR_W  destination of the head byte.
- out_data  output  DATA_W  payload byte.
- out_last  output  1  head byte is the last of its frame.
- err  output  1  one-cycle error pulse.
- err_code  output  2  cause; valid only while err=1. 0 = protocol, 1 = abort, 2 = misaligned end, 3 = overflow.

Behaviour:
- Reset values: busy_n=1, out_valid=0, out_addr=0, out_data=0, out_last=0, err=0, err_code=0. FIFO is emptied, state=IDLE. Reset asserted mid-frame discards all partial and buffered data.
- State machine: IDLE, ADDR, PAD, DATA, DROP.
- IDLE: when frame_n=0, `data` is taken as address bit 0. Next state is ADDR, or PAD if ADDR_W=1.
- ADDR: takes the remaining ADDR_W-1 address bits, one per cycle, with valid_n=1. Then goes to PAD.
- PAD: exactly PAD_CYCLES cycles with frame_n=0 and valid_n=1. `data` is ignored. Then goes to DATA.
- Errors in ADDR or PAD:
  - valid_n=0: err code 0, go to DROP.
  - frame_n=1: err code 1, go to IDLE.
- DATA, valid_n=1: stall cycle; nothing is sampled.
- DATA, valid_n=0: `data` is shifted in LSB first and the bit count increments.
  - On the DATA_W-th bit, the byte {addr, byte, last=frame_n} is written to the FIFO and the bit count clears.
- DATA, frame end:
  - frame_n=1 with valid_n=0 on a byte boundary ends the frame cleanly; go to IDLE.
  - frame_n=1 with valid_n=0 on a partial byte: err code 2, partial bits discarded, go to IDLE.
  - frame_n=1 with valid_n=1: err code 1, go to IDLE.
  - A frame with zero payload bytes is impossible; it ends via one of the error paths.
- Overflow: a byte completing while the FIFO is full is dropped with err code 3. If that was the last byte, go to IDLE; otherwise go to DROP.
- DROP: ignores all inputs until frame_n=1, then goes to IDLE. No err pulse on exit.
- Latency: a byte whose final bit is sampled at edge N appears at the FIFO head after edge N, i.e. out_valid=1 in cycle N+1 when the FIFO was empty. FIFO is show-ahead.
- Simultaneous write and read when full is allowed and is not an overflow: the pop frees the slot in the same edge.
- busy_n=0 whenever FIFO count >= DEPTH-1. The value is registered from post-edge count.
- Sender rules: the sender must hold valid_n=1 while it samples busy_n=0. The receiver does not enforce this beyond overflow detection.
- Frame boundaries: out_last is set exactly on the final byte of each clean frame. Bytes from different frames are never merged.
- Error precedence: only one err pulse per cycle. Order is overflow > misaligned > abort > protocol.

Test Plan:
- Clean frame to addr=4'hA: bits 0,1,0,1, 5 pad cycles, then bytes 8'h3C and 8'hA5 LSB first, frame_n=1 on the 16th payload bit, out_ready=1. Expect out_valid in the cycle after each 8th bit with {A,3C,last=0} then {A,A5,last=1}, and err never set.
- Stalls: same frame with valid_n=1 inserted after payload bits 3 and 11. Expect identical output bytes, each delayed by its stall count.
- Backpressure, DEPTH=4, out_ready=0, 5-byte frame:
  - busy_n=0 from the cycle after the 3rd byte is written.
  - If the sender ignores it, the 5th byte gives err=1, code=3, the FIFO holds 4 bytes, and out_last=1 never appears.
- Misaligned end: frame_n=1 on payload bit 12. Expect byte 1 delivered with last=0, then err=1, code=2, state back to IDLE, and the next frame received correctly.
- Protocol errors:
  - valid_n=0 during the 3rd pad cycle: err code 0 and no bytes out until frame_n=1.
  - frame_n=1 during ADDR: err code 1 and an immediate return to IDLE.
- Reset mid-DATA with 2 bytes buffered: outputs go to their reset values asynchronously, the FIFO is empty, and a new frame after reset is received correctly.
